// File: rtl/ex_commit_beta.sv
// ex_commit_beta: slave-pipe EX/MEM stage, two-entry skid buffer with overflow exception hold
// Optional EX_COMMIT_BETA_STATS_EN adds stat_commit/stat_exc commit counters.
module ex_commit_beta #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_result,
  input  logic                  in_reg_en,
  input  logic                  in_overflow,
  input  logic                  in_wen,
  input  logic [4:0]            in_waddr,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  in_delay_slot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic                  out_wen,
  output logic [4:0]            out_waddr,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_delay_slot,
  output logic                  out_exc,
  output logic [DEPTH-1:0]      fwd_valid,
  output logic [5*DEPTH-1:0]    fwd_waddr,
  output logic [32*DEPTH-1:0]   fwd_data
`ifdef EX_COMMIT_BETA_STATS_EN
  ,
  output logic [31:0]           stat_commit,
  output logic [31:0]           stat_exc
`endif
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam int EW = PC_W + 40;
  logic [1:0]      state;
  logic            exc_hold;
  logic [EW-1:0]   head, tail, in_e;
  logic            push, pop;
  logic [31:0]     h_result, t_result;
  logic            h_wen, t_wen, h_exc, t_exc, h_ds, t_ds;
  logic [4:0]      h_waddr, t_waddr;
  logic [PC_W-1:0] h_pc, t_pc;
  // wen is folded with the MOVN/MOVZ condition, overflow and the r0 check at capture
  assign in_e = {in_result, in_wen & in_reg_en & ~in_overflow & (|in_waddr),
                 in_overflow, in_waddr, in_pc, in_delay_slot};
  assign {h_result, h_wen, h_exc, h_waddr, h_pc, h_ds} = head;
  assign {t_result, t_wen, t_exc, t_waddr, t_pc, t_ds} = tail;
  assign in_ready       = rst && (state != FULL) && !exc_hold;
  assign out_valid      = (state != EMPTY);
  assign push           = in_valid && in_ready && !flush;
  assign pop            = out_valid && out_ready && !flush;
  assign out_result     = h_result;
  assign out_wen        = out_valid && h_wen;
  assign out_exc        = out_valid && h_exc;
  assign out_waddr      = h_waddr;
  assign out_pc         = h_pc;
  assign out_delay_slot = h_ds;
  assign fwd_valid      = {(state == FULL) && t_wen, out_valid && h_wen};
  assign fwd_waddr      = {t_waddr, h_waddr};
  assign fwd_data       = {t_result, h_result};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      exc_hold <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      exc_hold <= 1'b0;
    end else begin
      if (push && in_overflow) exc_hold <= 1'b1;
      if (state == EMPTY) begin
        if (push) begin
          head  <= in_e;
          state <= ONE;
        end
      end else if (state == ONE) begin
        if (push && !pop) begin
          tail  <= in_e;
          state <= FULL;
        end else if (push && pop) begin
          head <= in_e;
        end else if (pop) begin
          state <= EMPTY;
        end
      end else if (pop) begin
        head  <= tail;
        state <= ONE;
      end
    end
  end
`ifdef EX_COMMIT_BETA_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_commit <= '0;
      stat_exc    <= '0;
    end else begin
      if (pop && out_wen) stat_commit <= stat_commit + 32'd1;
      if (pop && out_exc) stat_exc <= stat_exc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ex_commit_beta.sv
// tb_ex_commit_beta: scoreboard bench for ex_commit_beta
module tb_ex_commit_beta;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_reg_en = 1'b0;
  logic        in_overflow = 1'b0;
  logic        in_wen = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_pc = '0;
  logic        in_delay_slot = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_wen;
  logic [4:0]  out_waddr;
  logic [31:0] out_pc;
  logic        out_delay_slot;
  logic        out_exc;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_data;
  typedef struct packed {
    logic [31:0] result;
    logic        wen;
    logic        exc;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic        ds;
  } ent_t;
  ent_t q[$];
  logic hold = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  ex_commit_beta dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_reg_en(in_reg_en), .in_overflow(in_overflow),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_pc(in_pc), .in_delay_slot(in_delay_slot),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wen(out_wen), .out_waddr(out_waddr), .out_pc(out_pc),
    .out_delay_slot(out_delay_slot), .out_exc(out_exc), .fwd_valid(fwd_valid),
    .fwd_waddr(fwd_waddr), .fwd_data(fwd_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    check("in_ready", in_ready, q.size() < 2 && !hold);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_result", out_result, q[0].result);
      check("out_wen", out_wen, q[0].wen);
      check("out_exc", out_exc, q[0].exc);
      check("out_waddr", out_waddr, q[0].waddr);
      check("out_pc", out_pc, q[0].pc);
      check("out_ds", out_delay_slot, q[0].ds);
      check("fwd_valid0", fwd_valid[0], q[0].wen);
      check("fwd_waddr0", fwd_waddr[4:0], q[0].waddr);
      check("fwd_data0", fwd_data[31:0], q[0].result);
    end else begin
      check("out_wen_idle", out_wen, 1'b0);
      check("out_exc_idle", out_exc, 1'b0);
      check("fwd_valid0_idle", fwd_valid[0], 1'b0);
    end
    check("fwd_valid1", fwd_valid[1], q.size() == 2 && q[1].wen);
    if (q.size() == 2) begin
      check("fwd_waddr1", fwd_waddr[9:5], q[1].waddr);
      check("fwd_data1", fwd_data[63:32], q[1].result);
    end
  endtask
  // one clock: check current outputs, drive inputs, advance the model across the edge
  task automatic step(input logic v, input logic [31:0] res, input logic [4:0] wa,
                      input logic we, input logic re, input logic ov,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    ent_t e;
    logic mpush, mpop;
    check_outputs();
    in_valid = v; in_result = res; in_waddr = wa; in_wen = we; in_reg_en = re;
    in_overflow = ov; in_pc = pc; in_delay_slot = pc[2]; out_ready = ordy; flush = fl;
    e = '{result: res, wen: we & re & ~ov & (wa != 0), exc: ov, waddr: wa, pc: pc, ds: pc[2]};
    mpush = v && q.size() < 2 && !hold && !fl;
    mpop = q.size() != 0 && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(e);
        if (ov) hold = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_wen", out_wen, 1'b0);
    check("rst_out_exc", out_exc, 1'b0);
    check("rst_fwd_valid", fwd_valid, 2'b00);
    check("rst_out_result", out_result, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    step(1, 32'h1234_5678, 5, 1, 1, 0, 32'h100, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) step(1, 32'hA000 + i, i[4:0], 1, 1, 0, 32'h200 + 4 * i, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h7777, 7, 1, 0, 0, 32'h300, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'hFFFF_FFFF, 9, 1, 1, 1, 32'hBFC0_0100, 0, 0);
    repeat (3) step(1, 32'h5555, 10, 1, 1, 0, 32'hBFC0_0104, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h6666, 11, 1, 1, 0, 32'h400, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h11, 12, 1, 1, 0, 32'h500, 0, 0);
    step(1, 32'h22, 13, 1, 1, 0, 32'h504, 0, 0);
    step(1, 32'h33, 14, 1, 1, 0, 32'h508, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h44, 0, 1, 1, 0, 32'h600, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, 5'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 32'h99, 3, 1, 1, 0, 32'h700, 0, 0);
    check_outputs();
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_out_wen", out_wen, 1'b0);
    check("async_fwd_valid", fwd_valid, 2'b00);
    q.delete();
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_commit_beta.md
Name: ex_commit_beta

Overview:
- Execute-to-memory stage register for the slave (beta) pipe, directly downstream of the slave ALU.
- Captures each ALU result together with its destination, conditional-move write enable and overflow flag.
- Buffers up to two results in a skid buffer with a valid/ready handshake.
- Suppresses the register write and raises a precise exception for overflowing ADD/SUB, then freezes intake until the pipe is flushed.

Parameters:
- DEPTH, 2, skid entries; fixed at 2, other values unsupported.
- PC_W, 32, width of the carried PC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipe flush, highest priority
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_result  in  32  ALU result
- in_reg_en  in  1  ALU ex_reg_en (MOVN/MOVZ condition)
- in_overflow  in  1  ALU exp_overflow
- in_wen  in  1  instruction writes a GPR
- in_waddr  in  5  destination GPR
- in_pc  in  PC_W  instruction PC
- in_delay_slot  in  1  instruction is in a branch delay slot
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_result  out  32  head result
- out_wen  out  1  effective write enable
- out_waddr  out  5  head destination
- out_pc  out  PC_W  head PC
- out_delay_slot  out  1  head delay-slot flag
- out_exc  out  1  head carries overflow exception
- fwd_valid  out  2  per-entry forward valid, bit0 = head, bit1 = tail
- fwd_waddr  out  10  {tail, head} destinations
- fwd_data  out  64  {tail, head} results

Behaviour:
- Reset (rst=0, asynchronous): count=0, exc_hold=0, all stored fields 0, all outputs 0.
- Reset is checked in the always_ff sensitivity list and applies immediately, including mid-transfer.
- Storage: two entries, head and tail, held in a state machine EMPTY / ONE / FULL.
- in_ready = (state != FULL) && !exc_hold.
  - It is a registered-state function only and never depends on out_ready.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- State transitions:
  - EMPTY: push -> ONE, with head loaded.
  - ONE: push and no pop -> FULL, with tail loaded.
  - ONE: pop and no push -> EMPTY.
  - ONE: push and pop -> ONE, with head replaced by the incoming entry.
  - FULL: pop -> ONE, with tail moved to head. Push is impossible in FULL.
- Latency: an accepted entry is visible on out_* the next cycle. No combinational path from in_* to out_*.
- Stored effective wen = in_wen & in_reg_en & ~in_overflow.
  - Stored exc = in_overflow.
  - A MOVN/MOVZ whose condition fails drains with out_wen=0 and out_exc=0.
- Exception hold: exc_hold is set on the cycle an entry with in_overflow=1 is pushed.
  - While exc_hold=1, in_ready=0. Existing entries still drain normally.
  - exc_hold clears only on flush.
- Flush: next state is EMPTY, exc_hold=0, and any same-cycle push or pop is discarded.
  - out_valid=0 from the following cycle. Flush wins over every other event.
- Outputs:
  - out_valid = (state != EMPTY).
  - When out_valid=0, out_wen and out_exc read 0; other out_* fields are don't-care but stable.
- Forwarding:
  - fwd_valid[i] = entry i occupied && its wen && waddr != 0.
  - An entry with waddr=0 never forwards and always reports out_wen=0.
- The block does no arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: EX_COMMIT_BETA_STATS_EN.
- Defined: adds outputs stat_commit (32) and stat_exc (32).
  - stat_commit increments on each pop with out_wen=1.
  - stat_exc increments on each pop with out_exc=1.
  - Both reset to 0 on rst, are not cleared by flush, and wrap from 0xFFFF_FFFF to 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then drive in_valid=1 for 1 cycle with result=0x1234_5678, waddr=5, wen=1, reg_en=1, overflow=0, out_ready=1.
  - Required: out_valid=1 and out_result=0x1234_5678 one cycle later, out_wen=1.
  - Required: fwd_valid[0]=1 with fwd_waddr[4:0]=5.
- Hold out_ready=0, push three back-to-back entries (waddr 1, 2, 3).
  - Required: in_ready=0 after the second push; only waddr 1 and 2 are stored.
  - Then raise out_ready: required output order 1 then 2, and in_ready=1 after the first pop.
- Push an entry with reg_en=0, wen=1, waddr=7.
  - Required: out_valid=1, out_wen=0, out_exc=0, fwd_valid=0.
- Push an entry with overflow=1, pc=0xBFC0_0100, followed by a second valid entry.
  - Required: out_exc=1, out_wen=0, out_pc=0xBFC0_0100.
  - Required: in_ready=0 until flush; the second entry is not accepted.
  - Then pulse flush: required out_valid=0 next cycle, in_ready=1.
- With state FULL, assert flush together with out_ready=1 and in_valid=1.
  - Required: next cycle EMPTY, no pop counted, nothing accepted.
  - Separately, assert rst=0 asynchronously mid-cycle: required out_valid=0 immediately.
